// File: rtl/peak_list_buffer_if.sv
// Bus between a peak detector / consumer pair and peak_list_buffer.
// The DUT uses the slave view; the driving side uses the master view.
interface peak_list_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              start;
  logic              peak_detected;
  logic [ADDR_W-1:0] peak_addr;
  logic [DATA_W-1:0] peak_value;
  logic              done;
  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_value;
  logic [CNT_W-1:0]  peak_count;
  logic              overflow;
  logic [ADDR_W-1:0] max_addr;
  logic [DATA_W-1:0] max_value;
  logic              max_valid;
  logic              run_complete;

  modport master (
    output start, peak_detected, peak_addr, peak_value, done, rd_ready,
    input  rd_valid, rd_addr, rd_value, peak_count, overflow,
           max_addr, max_value, max_valid, run_complete
  );

  modport slave (
    input  start, peak_detected, peak_addr, peak_value, done, rd_ready,
    output rd_valid, rd_addr, rd_value, peak_count, overflow,
           max_addr, max_value, max_valid, run_complete
  );
endinterface

// File: rtl/peak_list_buffer.sv
// Collects detector peaks of one scan into a FWFT FIFO and tracks the
// largest peak of the run; the list is drained during and after the scan.
module peak_list_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic clk,
  input  logic reset,
  peak_list_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_REPORT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;
  } entry_t;

  state_t            r_state;
  state_t            w_state_nxt;
  entry_t            r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [ADDR_W-1:0] r_max_addr;
  logic [DATA_W-1:0] r_max_value;
  logic              r_max_valid;

  logic w_rd_valid;
  logic w_full;
  logic w_pop;
  logic w_peak;
  logic w_push;
  logic w_drop;
  logic w_max_upd;

  // start wins over everything else in its cycle, so it masks peak handling.
  assign w_rd_valid = (r_state != S_IDLE) && (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_pop      = w_rd_valid && bus.rd_ready && !bus.start;
  assign w_peak     = (r_state == S_COLLECT) && bus.peak_detected && !bus.start;
  assign w_push     = w_peak && (!w_full || w_pop);
  assign w_drop     = w_peak && w_full && !w_pop;
  assign w_max_upd  = w_peak && (!r_max_valid || (bus.peak_value > r_max_value));

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = S_COLLECT;
    end else if ((r_state == S_COLLECT) && bus.done) begin
      w_state_nxt = S_REPORT;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: storage has no reset; the pointers and count define which words are
  // meaningful, and leaving the array unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{addr: bus.peak_addr, value: bus.peak_value};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Dropped peaks still compete for the maximum; ties keep the earlier address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_max_addr  <= '0;
      r_max_value <= '0;
      r_max_valid <= 1'b0;
    end else if (bus.start) begin
      r_overflow  <= 1'b0;
      r_max_addr  <= '0;
      r_max_value <= '0;
      r_max_valid <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_max_upd) begin
        r_max_addr  <= bus.peak_addr;
        r_max_value <= bus.peak_value;
        r_max_valid <= 1'b1;
      end
    end
  end

  assign bus.rd_valid     = w_rd_valid;
  assign bus.rd_addr      = r_mem[r_rd_ptr].addr;
  assign bus.rd_value     = r_mem[r_rd_ptr].value;
  assign bus.peak_count   = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.max_addr     = r_max_addr;
  assign bus.max_value    = r_max_value;
  assign bus.max_valid    = r_max_valid;
  assign bus.run_complete = (r_state == S_REPORT);
endmodule

// File: tb/tb_peak_list_buffer.sv
// Directed bench for peak_list_buffer: inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_peak_list_buffer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  peak_list_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  peak_list_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  task automatic do_peak(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    bus.peak_detected = 1'b1;
    bus.peak_addr     = a;
    bus.peak_value    = v;
    tick();
    bus.peak_detected = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] v);
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_addr"},  32'(bus.rd_addr),  32'(a));
    check({tag, "_value"}, 32'(bus.rd_value), 32'(v));
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_count"},    32'(bus.peak_count),   32'd0);
    check({tag, "_rdvalid"},  32'(bus.rd_valid),     32'd0);
    check({tag, "_ovf"},      32'(bus.overflow),     32'd0);
    check({tag, "_maxvalid"}, 32'(bus.max_valid),    32'd0);
    check({tag, "_maxaddr"},  32'(bus.max_addr),     32'd0);
    check({tag, "_maxvalue"}, 32'(bus.max_value),    32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.peak_detected = 1'b0;
    bus.peak_addr = '0;
    bus.peak_value = '0;
    bus.done = 1'b0;
    bus.rd_ready = 1'b0;

    // Reset state, then stay idle after release; idle ignores peaks.
    #12;
    check_cleared("rst");
    check("rst_runc", 32'(bus.run_complete), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    check("idle_rdvalid", 32'(bus.rd_valid), 32'd0);
    check("idle_runc", 32'(bus.run_complete), 32'd0);
    do_peak(10'd3, 8'h55);
    check("idle_peak_count", 32'(bus.peak_count), 32'd0);
    check("idle_peak_maxv", 32'(bus.max_valid), 32'd0);

    // Basic run: three peaks, tie on 0x80 keeps address 9.
    do_start();
    check("run1_runc0", 32'(bus.run_complete), 32'd0);
    do_peak(10'd5, 8'h20);
    check("run1_lat_valid", 32'(bus.rd_valid), 32'd1);
    do_peak(10'd9, 8'h80);
    do_peak(10'd12, 8'h80);
    check("run1_pre_done_runc", 32'(bus.run_complete), 32'd0);
    do_done();
    check("run1_runc", 32'(bus.run_complete), 32'd1);
    check("run1_count", 32'(bus.peak_count), 32'd3);
    check("run1_maxaddr", 32'(bus.max_addr), 32'd9);
    check("run1_maxvalue", 32'(bus.max_value), 32'h80);
    check("run1_maxvalid", 32'(bus.max_valid), 32'd1);
    do_peak(10'd7, 8'hFF);
    check("report_peak_count", 32'(bus.peak_count), 32'd3);
    check("report_peak_max", 32'(bus.max_value), 32'h80);
    do_done();
    check("report_done_runc", 32'(bus.run_complete), 32'd1);
    check("report_done_count", 32'(bus.peak_count), 32'd3);
    pop_check("run1_rd0", 10'd5, 8'h20);
    pop_check("run1_rd1", 10'd9, 8'h80);
    pop_check("run1_rd2", 10'd12, 8'h80);
    check("run1_empty", 32'(bus.rd_valid), 32'd0);
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    check("run1_empty_pop_count", 32'(bus.peak_count), 32'd0);

    // Full FIFO with simultaneous write and read, then wrap-around.
    do_start();
    check_cleared("run2_start");
    check("run2_runc", 32'(bus.run_complete), 32'd0);
    for (int i = 0; i < 8; i++) do_peak(10'(100 + i), 8'(16 + i));
    check("run2_full_count", 32'(bus.peak_count), 32'd8);
    check("run2_full_ovf", 32'(bus.overflow), 32'd0);
    check("run2_head", 32'(bus.rd_addr), 32'd100);
    bus.peak_detected = 1'b1;
    bus.peak_addr     = 10'd200;
    bus.peak_value    = 8'h02;
    bus.rd_ready      = 1'b1;
    tick();
    bus.peak_detected = 1'b0;
    bus.rd_ready      = 1'b0;
    check("run2_rw_count", 32'(bus.peak_count), 32'd8);
    check("run2_rw_ovf", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 8; i++) pop_check($sformatf("run2_rd%0d", i), 10'(100 + i), 8'(16 + i));
    pop_check("run2_rd_new", 10'd200, 8'h02);
    check("run2_drained", 32'(bus.rd_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      do_peak(10'(300 + i), 8'(i));
      pop_check($sformatf("wrap%0d", i), 10'(300 + i), 8'(i));
    end
    check("wrap_count", 32'(bus.peak_count), 32'd0);
    check("run2_maxaddr", 32'(bus.max_addr), 32'd107);
    check("run2_maxvalue", 32'(bus.max_value), 32'h17);

    // Overflow: 10 peaks into 8 slots, dropped 0xFF still wins the maximum.
    do_start();
    for (int i = 0; i < 8; i++) do_peak(10'(100 + i), 8'(16 + i));
    do_peak(10'd108, 8'hFF);
    do_peak(10'd109, 8'h01);
    check("ovf_count", 32'(bus.peak_count), 32'd8);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_maxvalue", 32'(bus.max_value), 32'hFF);
    check("ovf_maxaddr", 32'(bus.max_addr), 32'd108);
    check("ovf_head", 32'(bus.rd_addr), 32'd100);

    // start coinciding with a peak: the peak is discarded.
    bus.peak_detected = 1'b1;
    bus.peak_addr     = 10'd55;
    bus.peak_value    = 8'hEE;
    do_start();
    bus.peak_detected = 1'b0;
    check_cleared("startpk");
    check("startpk_runc", 32'(bus.run_complete), 32'd0);

    // Peak together with done: stored, then REPORT; start from REPORT clears.
    do_peak(10'd50, 8'h33);
    bus.done = 1'b1;
    do_peak(10'd51, 8'h44);
    bus.done = 1'b0;
    check("pkdone_count", 32'(bus.peak_count), 32'd2);
    check("pkdone_runc", 32'(bus.run_complete), 32'd1);
    check("pkdone_maxaddr", 32'(bus.max_addr), 32'd51);
    do_start();
    check_cleared("rep_start");
    check("rep_start_runc", 32'(bus.run_complete), 32'd0);

    // Asynchronous reset mid-cycle with four entries stored.
    for (int i = 0; i < 4; i++) do_peak(10'(400 + i), 8'(32 + i));
    check("arst_pre_count", 32'(bus.peak_count), 32'd4);
    #3;
    reset = 1'b0;
    #1;
    check_cleared("arst");
    check("arst_runc", 32'(bus.run_complete), 32'd0);
    #2;
    reset = 1'b1;
    tick();
    check("arst_post_rdvalid", 32'(bus.rd_valid), 32'd0);
    check("arst_post_count", 32'(bus.peak_count), 32'd0);
    do_peak(10'd9, 8'h99);
    check("arst_idle_count", 32'(bus.peak_count), 32'd0);
    check("arst_idle_maxv", 32'(bus.max_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
